trie_stage_ctrl: RTL and testbench
==================================

// Module: trie_stage_ctrl
// PURPOSE
//  Per-stage control for the 4-bit trie lookup pipeline; one instance sits between RAM stage s and RAM s+1.
//  Consumes the entry read from stage s (exist + nexthop + child block index) together with the lookup context.
//  Updates the longest-match nexthop and drives the address of stage s+1.
//  Delays the context so it arrives aligned with that RAM's registered dout.
// PARAMETERS
//  STAGE_IDX   0   index s of the RAM whose dout this block consumes (0 = root)
//  IP_WIDTH    32  lookup key width; number of stages = IP_WIDTH/4
//  NH_WIDTH    8   nexthop width
//  PTR_WIDTH   10  child block index width; next address = {ptr, nibble}, so PTR_WIDTH+4 bits
//  DATA_WIDTH  1+NH_WIDTH+PTR_WIDTH  RAM word: [MSB]=exist, then nexthop, then ptr in the LSBs
// PORTS
//  clk          in   1             pipeline clock
//  rst          in   1             asynchronous, active-high reset
//  ram_dout     in   DATA_WIDTH    stage-s RAM word, valid in the same cycle as in_valid
//  in_valid     in   1             lookup context present
//  in_live      in   1             lookup still walking; ram_dout meaningful only when in_valid && in_live
//  in_ip        in   IP_WIDTH      lookup key
//  in_nh        in   NH_WIDTH      best nexthop found so far
//  in_nh_vld    in   1             in_nh is valid
//  flush        in   1             synchronous: drop all in-flight lookups
//  nxt_addr     out  PTR_WIDTH+4   address to stage s+1 RAM, registered
//  out_valid    out  1             context for stage s+1, aligned with that RAM's dout
//  out_live     out  1
//  out_ip       out  IP_WIDTH
//  out_nh       out  NH_WIDTH
//  out_nh_vld   out  1
// BEHAVIOUR
//  Reset: every output register is 0, including nxt_addr and the internal delay register.
//  Cycle T, decode when in_valid:
//   - hit  = in_live & ram_dout.exist
//   - nh   = hit ? ram_dout.nexthop : in_nh
//   - vld  = in_nh_vld | hit
//   - live = in_live & (ptr != 0) & (STAGE_IDX < IP_WIDTH/4-1)
//   - ptr 0 is the null block and ends the walk.
//  Nibble: key bits [IP_WIDTH-1-4*(STAGE_IDX+1) -: 4].
//  Address at T+1: nxt_addr <= live ? {ptr, nibble} : 0.
//   - nxt_addr updates only when in_valid; otherwise it holds its value.
//  Context: captured at T+1 into a stage register, then moved to the output register at T+2.
//   - Total latency is 2 cycles for context and 1 cycle for the address.
//   - Throughput is one lookup per clock; there is no backpressure.
//  in_valid=0: a bubble propagates, with out_valid=0 two cycles later.
//   - The payload registers may hold stale data but must not be used.
//  Last stage (STAGE_IDX = IP_WIDTH/4-1):
//   - out_live=0 and nxt_addr=0; nexthop update still applies.
//   - out_nh/out_nh_vld is the final result.
//  in_live=0 with in_valid=1: ram_dout is ignored; nh/vld pass through unchanged; out_live=0.
//  flush=1: clears the valid bits of both internal registers in the same edge; payload is don't-care.
//   - flush takes precedence over a simultaneous in_valid.
//  rst mid-walk: all lookups are discarded asynchronously; nothing resumes after release.
// CONFIGURATION
//  TRIE_STAGE_STATS_EN defined adds:
//   - stat_lookups (32 bit, out): +1 per in_valid & in_live.
//   - stat_hits (32 bit, out): +1 per hit.
//   - stat_clr (in): synchronous clear; takes priority over an increment in the same cycle.
//   - Counters saturate at all-ones and reset to 0.
//  Not defined: these ports and counters are absent; the datapath is identical.
// STRUCTURE
//  Shared package trie_pkg holds:
//   - NH_WIDTH, PTR_WIDTH, IP_WIDTH, and NIBBLE=4.
//   - Field offsets EXIST_BIT, NH_LSB, PTR_LSB.
//   - Typedef trie_ctx_t = {valid, live, ip, nh, nh_vld}.
//  Sub-module trie_ctx_reg: one register of trie_ctx_t with async reset and flush; instantiated twice.
// TESTING
//  1. STAGE_IDX=0, ip=32'hA5000000, dout={1,8'h07,10'd3}
//     -> nxt_addr=14'h035 at T+1; out_nh=07, out_nh_vld=1, out_live=1 at T+2.
//  2. dout exist=0, ptr=5, in_nh=8'h22 with in_nh_vld=1
//     -> out_nh=22 kept; nxt_addr={5, nibble}.
//  3. ptr=0
//     -> nxt_addr=0, out_live=0; next cycle in_live=0 passes nh through and ignores a nonzero dout.
//  4. Back-to-back lookups, 4 consecutive valids with distinct ips
//     -> 4 consecutive out_valid in order, 2-cycle latency, no loss.
//  5. flush asserted with 2 lookups in flight
//     -> no out_valid; a new lookup in the next cycle emerges normally.
//  6. rst asserted mid-stream with STATS on
//     -> all outputs and counters 0 immediately; 2^32-1 hits saturate and stat_clr clears them.

Source files
------------

// File: rtl/trie_pkg.sv
// Shared widths, RAM word field offsets and the per-lookup context record
// for the 4-bit trie lookup pipeline.
package trie_pkg;

    localparam int IP_WIDTH   = 32;
    localparam int NH_WIDTH   = 8;
    localparam int PTR_WIDTH  = 10;
    localparam int NIBBLE     = 4;
    localparam int DATA_WIDTH = 1 + NH_WIDTH + PTR_WIDTH;

    // RAM word layout: exist flag on top, nexthop in the middle, child pointer in the LSBs
    localparam int EXIST_BIT = DATA_WIDTH - 1;
    localparam int NH_LSB    = PTR_WIDTH;
    localparam int PTR_LSB   = 0;

    typedef struct packed {
        logic                valid;
        logic                live;
        logic [IP_WIDTH-1:0] ip;
        logic [NH_WIDTH-1:0] nh;
        logic                nh_vld;
    } trie_ctx_t;

    // Key nibble that selects the entry inside the child block read by the next stage.
    // The last stage has no successor; its shift clamps to 0 and the result is unused.
    function automatic logic [NIBBLE-1:0] key_nibble(input logic [IP_WIDTH-1:0] ip,
                                                     input int               stage);
        int sh;
        sh = IP_WIDTH - NIBBLE * (stage + 2);
        if (sh < 0) begin
            sh = 0;
        end
        return ip[sh +: NIBBLE];
    endfunction

endpackage

// File: rtl/trie_ctx_reg.sv
// One pipeline register holding a lookup context; 1-cycle latency, no backpressure.
// flush drops the held lookup by clearing only its valid bit.
module trie_ctx_reg
    import trie_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  trie_ctx_t i_ctx,
    output trie_ctx_t o_ctx
);

    trie_ctx_t r_ctx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctx <= '0;
        end else begin
            r_ctx       <= i_ctx;
            r_ctx.valid <= i_ctx.valid & ~i_flush;
        end
    end

    assign o_ctx = r_ctx;

endmodule

// File: rtl/trie_stage_ctrl.sv
// Per-stage trie control: next-RAM address 1 cycle after the entry, context 2 cycles, one lookup/clock, no backpressure.
// Optional hit/lookup counters are built when TRIE_STAGE_STATS_EN is defined.
module trie_stage_ctrl #(
    parameter int STAGE_IDX  = 0,
    parameter int IP_WIDTH   = trie_pkg::IP_WIDTH,
    parameter int NH_WIDTH   = trie_pkg::NH_WIDTH,
    parameter int PTR_WIDTH  = trie_pkg::PTR_WIDTH,
    parameter int DATA_WIDTH = 1 + NH_WIDTH + PTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ram_dout,
    input  logic                   in_valid,
    input  logic                   in_live,
    input  logic [IP_WIDTH-1:0]    in_ip,
    input  logic [NH_WIDTH-1:0]    in_nh,
    input  logic                   in_nh_vld,
    input  logic                   flush,
`ifdef TRIE_STAGE_STATS_EN
    input  logic                   stat_clr,
    output logic [31:0]            stat_lookups,
    output logic [31:0]            stat_hits,
`endif
    output logic [PTR_WIDTH+3:0]   nxt_addr,
    output logic                   out_valid,
    output logic                   out_live,
    output logic [IP_WIDTH-1:0]    out_ip,
    output logic [NH_WIDTH-1:0]    out_nh,
    output logic                   out_nh_vld
);

    import trie_pkg::*;

    localparam int   NSTAGES = IP_WIDTH / NIBBLE;
    localparam logic LAST    = (STAGE_IDX >= NSTAGES - 1);

    logic                  w_exist;
    logic [NH_WIDTH-1:0]   w_dout_nh;
    logic [PTR_WIDTH-1:0]  w_ptr;
    logic                  w_hit;
    logic                  w_live;
    logic [NIBBLE-1:0]     w_nibble;
    logic [PTR_WIDTH+3:0]  w_addr;
    trie_ctx_t             w_stage_d;
    trie_ctx_t             w_stage_q;
    trie_ctx_t             w_out_q;
    logic [PTR_WIDTH+3:0]  r_nxt_addr;

    assign w_exist   = ram_dout[EXIST_BIT];
    assign w_dout_nh = ram_dout[NH_LSB +: NH_WIDTH];
    assign w_ptr     = ram_dout[PTR_LSB +: PTR_WIDTH];

    // A retired lookup ignores the RAM word entirely; ptr 0 is the null block
    assign w_hit    = in_live & w_exist;
    assign w_live   = in_live & (|w_ptr) & ~LAST;
    assign w_nibble = key_nibble(in_ip, STAGE_IDX);
    assign w_addr   = w_live ? {w_ptr, w_nibble} : '0;

    always_comb begin
        w_stage_d        = '0;
        w_stage_d.valid  = in_valid;
        w_stage_d.live   = w_live;
        w_stage_d.ip     = in_ip;
        w_stage_d.nh     = w_hit ? w_dout_nh : in_nh;
        w_stage_d.nh_vld = in_nh_vld | w_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nxt_addr <= '0;
        end else if (in_valid & ~flush) begin
            r_nxt_addr <= w_addr;
        end
    end

    // Two context registers line the lookup up with the next RAM's registered dout
    trie_ctx_reg u_stage_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_ctx   (w_stage_d),
        .o_ctx   (w_stage_q)
    );

    trie_ctx_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_ctx   (w_stage_q),
        .o_ctx   (w_out_q)
    );

    assign nxt_addr   = r_nxt_addr;
    assign out_valid  = w_out_q.valid;
    assign out_live   = w_out_q.live;
    assign out_ip     = w_out_q.ip;
    assign out_nh     = w_out_q.nh;
    assign out_nh_vld = w_out_q.nh_vld;

`ifdef TRIE_STAGE_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_hits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
        end else if (stat_clr) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
        end else begin
            if (in_valid & in_live & ~(&r_stat_lookups)) begin
                r_stat_lookups <= r_stat_lookups + 32'd1;
            end
            if (in_valid & w_hit & ~(&r_stat_hits)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
        end
    end

    assign stat_lookups = r_stat_lookups;
    assign stat_hits    = r_stat_hits;
`endif

endmodule

// File: tb/tb_trie_stage_ctrl.sv
// Bench for trie_stage_ctrl: a root-stage and a last-stage instance share stimulus
// and are compared each cycle against a lookup-history reference model.
module tb_trie_stage_ctrl;

    typedef struct packed {
        logic        v;
        logic        live;
        logic [31:0] ip;
        logic [7:0]  nh;
        logic        nhv;
        logic [13:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] ram_dout = '0;
    logic        in_valid = 1'b0;
    logic        in_live = 1'b0;
    logic [31:0] in_ip = '0;
    logic [7:0]  in_nh = '0;
    logic        in_nh_vld = 1'b0;
    logic        flush = 1'b0;

    logic [13:0] d0_nxt_addr, d7_nxt_addr;
    logic        d0_out_valid, d0_out_live, d0_out_nh_vld;
    logic        d7_out_valid, d7_out_live, d7_out_nh_vld;
    logic [31:0] d0_out_ip, d7_out_ip;
    logic [7:0]  d0_out_nh, d7_out_nh;

`ifdef TRIE_STAGE_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] d0_lookups, d0_hits, d7_lookups, d7_hits;
    logic [31:0] exp_lookups, exp_hits;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t pend;
    exp_t outp;
    logic [13:0] exp_addr;

    always #5 clk = ~clk;

    trie_stage_ctrl #(.STAGE_IDX(0)) dut (
        .clk(clk), .rst(rst), .ram_dout(ram_dout), .in_valid(in_valid), .in_live(in_live),
        .in_ip(in_ip), .in_nh(in_nh), .in_nh_vld(in_nh_vld), .flush(flush),
`ifdef TRIE_STAGE_STATS_EN
        .stat_clr(stat_clr), .stat_lookups(d0_lookups), .stat_hits(d0_hits),
`endif
        .nxt_addr(d0_nxt_addr), .out_valid(d0_out_valid), .out_live(d0_out_live),
        .out_ip(d0_out_ip), .out_nh(d0_out_nh), .out_nh_vld(d0_out_nh_vld)
    );

    trie_stage_ctrl #(.STAGE_IDX(7)) dut_last (
        .clk(clk), .rst(rst), .ram_dout(ram_dout), .in_valid(in_valid), .in_live(in_live),
        .in_ip(in_ip), .in_nh(in_nh), .in_nh_vld(in_nh_vld), .flush(flush),
`ifdef TRIE_STAGE_STATS_EN
        .stat_clr(stat_clr), .stat_lookups(d7_lookups), .stat_hits(d7_hits),
`endif
        .nxt_addr(d7_nxt_addr), .out_valid(d7_out_valid), .out_live(d7_out_live),
        .out_ip(d7_out_ip), .out_nh(d7_out_nh), .out_nh_vld(d7_out_nh_vld)
    );

    // Result of one lookup at the root stage, straight from the lookup rules
    function automatic exp_t model_eval();
        exp_t        e;
        logic        hit;
        logic [9:0]  ptr;
        hit    = in_live & ram_dout[18];
        ptr    = ram_dout[9:0];
        e.v    = in_valid;
        e.ip   = in_ip;
        e.nh   = hit ? ram_dout[17:10] : in_nh;
        e.nhv  = in_nh_vld | hit;
        e.live = in_live && (ptr != 10'd0);
        e.addr = e.live ? {ptr, in_ip[27:24]} : 14'h0;
        return e;
    endfunction

    task automatic reset_model();
        pend     = '0;
        outp     = '0;
        exp_addr = '0;
`ifdef TRIE_STAGE_STATS_EN
        exp_lookups = '0;
        exp_hits    = '0;
`endif
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] ip,
                         input logic [18:0] dout, input logic [7:0] nh, input logic nhv,
                         input logic f);
        in_valid  = v;
        in_live   = l;
        in_ip     = ip;
        ram_dout  = dout;
        in_nh     = nh;
        in_nh_vld = nhv;
        flush     = f;
    endtask

    // One clock edge; afterwards outp is the lookup due at the outputs, exp_addr the address
    task automatic advance();
        exp_t e;
        e = model_eval();
        if (flush) begin
            pend.v = 1'b0;
            e.v    = 1'b0;
        end
`ifdef TRIE_STAGE_STATS_EN
        if (stat_clr) begin
            exp_lookups = '0;
            exp_hits    = '0;
        end else begin
            if (in_valid && in_live && exp_lookups != 32'hFFFF_FFFF) exp_lookups++;
            if (in_valid && in_live && ram_dout[18] && exp_hits != 32'hFFFF_FFFF) exp_hits++;
        end
`endif
        @(posedge clk);
        #1;
        outp = pend;
        pend = e;
        if (in_valid && !flush) exp_addr = e.addr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({d0_nxt_addr, d0_out_valid, d0_out_live, d0_out_ip, d0_out_nh, d0_out_nh_vld} !== '0) begin
            n_errors++;
            $display("FAIL reset_root got addr=%h v=%b l=%b ip=%h nh=%h nhv=%b want all 0",
                     d0_nxt_addr, d0_out_valid, d0_out_live, d0_out_ip, d0_out_nh, d0_out_nh_vld);
        end
        n_checks++;
        if ({d7_nxt_addr, d7_out_valid, d7_out_live, d7_out_ip, d7_out_nh, d7_out_nh_vld} !== '0) begin
            n_errors++;
            $display("FAIL reset_last got addr=%h v=%b nh=%h want all 0", d7_nxt_addr, d7_out_valid, d7_out_nh);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_hit();
        drive(1, 1, 32'hA500_0000, {1'b1, 8'h07, 10'd3}, 8'h00, 0, 0);
        advance();
        n_checks++;
        if (d0_nxt_addr !== 14'h035) begin
            n_errors++;
            $display("FAIL hit_addr got %h want 035", d0_nxt_addr);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        advance();
        n_checks++;
        if ({d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld, d0_out_ip} !== {1'b1, 1'b1, 8'h07, 1'b1, 32'hA500_0000}) begin
            n_errors++;
            $display("FAIL hit_ctx got v=%b l=%b nh=%h nhv=%b ip=%h want 1 1 07 1 a5000000",
                     d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld, d0_out_ip);
        end
        n_checks++;
        if ({d7_nxt_addr, d7_out_valid, d7_out_live, d7_out_nh, d7_out_nh_vld} !== {14'h0, 1'b1, 1'b0, 8'h07, 1'b1}) begin
            n_errors++;
            $display("FAIL hit_last got addr=%h v=%b l=%b nh=%h nhv=%b want 0 1 0 07 1",
                     d7_nxt_addr, d7_out_valid, d7_out_live, d7_out_nh, d7_out_nh_vld);
        end
    endtask

    task automatic test_miss();
        drive(1, 1, 32'h1C00_0000, {1'b0, 8'hEE, 10'd5}, 8'h22, 1, 0);
        advance();
        n_checks++;
        if (d0_nxt_addr !== 14'h05C) begin
            n_errors++;
            $display("FAIL miss_addr got %h want 05c", d0_nxt_addr);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        advance();
        n_checks++;
        if ({d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld} !== {1'b1, 1'b1, 8'h22, 1'b1}) begin
            n_errors++;
            $display("FAIL miss_ctx got v=%b l=%b nh=%h nhv=%b want 1 1 22 1",
                     d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld);
        end
    endtask

    task automatic test_null_ptr();
        drive(1, 1, 32'h3700_0000, {1'b1, 8'h44, 10'd0}, 8'h00, 0, 0);
        advance();
        n_checks++;
        if (d0_nxt_addr !== 14'h0) begin
            n_errors++;
            $display("FAIL null_addr got %h want 0", d0_nxt_addr);
        end
        drive(1, 0, 32'h3700_0000, {1'b1, 8'h99, 10'd7}, 8'h31, 0, 0);
        advance();
        n_checks++;
        if ({d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld} !== {1'b1, 1'b0, 8'h44, 1'b1}) begin
            n_errors++;
            $display("FAIL null_ctx got v=%b l=%b nh=%h nhv=%b want 1 0 44 1",
                     d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld);
        end
        n_checks++;
        if (d0_nxt_addr !== 14'h0) begin
            n_errors++;
            $display("FAIL dead_addr got %h want 0", d0_nxt_addr);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        advance();
        n_checks++;
        if ({d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld} !== {1'b1, 1'b0, 8'h31, 1'b0}) begin
            n_errors++;
            $display("FAIL dead_ctx got v=%b l=%b nh=%h nhv=%b want 1 0 31 0",
                     d0_out_valid, d0_out_live, d0_out_nh, d0_out_nh_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ips [4];
        logic [31:0] seen [$];
        for (int k = 0; k < 4; k++) ips[k] = {4'h0, 4'(k + 1), 24'h0} | 32'(k * 17 + 1);
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1, 1, ips[c], {1'b1, 8'(8'h10 + c), 10'(c + 1)}, 8'h00, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            advance();
            n_checks++;
            if (d0_out_valid !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
                n_errors++;
                $display("FAIL b2b_valid cycle %0d got %b want %b", c, d0_out_valid, (c >= 1 && c <= 4));
            end
            if (d0_out_valid === 1'b1) seen.push_back(d0_out_ip);
        end
        n_checks++;
        if (seen.size() != 4 || seen[0] !== ips[0] || seen[1] !== ips[1] || seen[2] !== ips[2] || seen[3] !== ips[3]) begin
            n_errors++;
            $display("FAIL b2b_order got %0d lookups want 4 in order %h %h %h %h",
                     seen.size(), ips[0], ips[1], ips[2], ips[3]);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 32'h0100_0000, {1'b1, 8'h55, 10'd9}, 8'h00, 0, 0);
        advance();
        drive(1, 1, 32'h0200_0000, {1'b1, 8'h66, 10'd9}, 8'h00, 0, 1);
        advance();
        n_checks++;
        if (d0_out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_out1 got %b want 0", d0_out_valid);
        end
        drive(1, 1, 32'h0900_0000, {1'b1, 8'h77, 10'd2}, 8'h00, 0, 0);
        advance();
        n_checks++;
        if (d0_out_valid !== 1'b0 || d0_nxt_addr !== 14'h029) begin
            n_errors++;
            $display("FAIL flush_out2 got v=%b addr=%h want 0 029", d0_out_valid, d0_nxt_addr);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        advance();
        n_checks++;
        if ({d0_out_valid, d0_out_ip, d0_out_nh} !== {1'b1, 32'h0900_0000, 8'h77}) begin
            n_errors++;
            $display("FAIL flush_next got v=%b ip=%h nh=%h want 1 09000000 77", d0_out_valid, d0_out_ip, d0_out_nh);
        end
    endtask

    task automatic test_random();
        logic [9:0] ptr;
        for (int c = 0; c < 400; c++) begin
            ptr = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom,
                  {1'($urandom_range(0, 1)), 8'($urandom), ptr}, 8'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
`ifdef TRIE_STAGE_STATS_EN
            stat_clr = ($urandom_range(0, 63) == 0);
`endif
            advance();
            n_checks++;
            if (d0_out_valid !== outp.v || d7_out_valid !== outp.v) begin
                n_errors++;
                $display("FAIL rnd_valid cycle %0d got %b/%b want %b", c, d0_out_valid, d7_out_valid, outp.v);
            end
            n_checks++;
            if (d0_nxt_addr !== exp_addr || d7_nxt_addr !== 14'h0) begin
                n_errors++;
                $display("FAIL rnd_addr cycle %0d got %h/%h want %h/0", c, d0_nxt_addr, d7_nxt_addr, exp_addr);
            end
            if (outp.v) begin
                n_checks++;
                if ({d0_out_live, d0_out_ip, d0_out_nh, d0_out_nh_vld} !== {outp.live, outp.ip, outp.nh, outp.nhv} ||
                    {d7_out_live, d7_out_nh, d7_out_nh_vld} !== {1'b0, outp.nh, outp.nhv}) begin
                    n_errors++;
                    $display("FAIL rnd_ctx cycle %0d got l=%b ip=%h nh=%h nhv=%b last l=%b want %b %h %h %b last 0",
                             c, d0_out_live, d0_out_ip, d0_out_nh, d0_out_nh_vld, d7_out_live,
                             outp.live, outp.ip, outp.nh, outp.nhv);
                end
            end
`ifdef TRIE_STAGE_STATS_EN
            n_checks++;
            if (d0_lookups !== exp_lookups || d0_hits !== exp_hits || d7_hits !== exp_hits) begin
                n_errors++;
                $display("FAIL rnd_stats cycle %0d got %0d/%0d want %0d/%0d", c, d0_lookups, d0_hits, exp_lookups, exp_hits);
            end
`endif
        end
`ifdef TRIE_STAGE_STATS_EN
        stat_clr = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_rst_mid();
        drive(1, 1, 32'hA500_0000, {1'b1, 8'h07, 10'd3}, 8'h00, 0, 0);
        advance();
        advance();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({d0_nxt_addr, d0_out_valid, d0_out_live, d0_out_ip, d0_out_nh, d0_out_nh_vld} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid got addr=%h v=%b nh=%h want all 0", d0_nxt_addr, d0_out_valid, d0_out_nh);
        end
`ifdef TRIE_STAGE_STATS_EN
        n_checks++;
        if (d0_lookups !== 32'd0 || d0_hits !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_stats got %0d/%0d want 0/0", d0_lookups, d0_hits);
        end
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int c = 0; c < 3; c++) begin
            advance();
            n_checks++;
            if (d0_out_valid !== 1'b0 || d0_nxt_addr !== 14'h0) begin
                n_errors++;
                $display("FAIL rst_resume cycle %0d got v=%b addr=%h want 0 0", c, d0_out_valid, d0_nxt_addr);
            end
        end
    endtask

`ifdef TRIE_STAGE_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        advance();
        stat_clr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, $urandom, {1'b1, 8'h01, 10'd1}, 0, 0, 0);
            advance();
        end
        drive(1, 1, 0, {1'b0, 8'h01, 10'd1}, 0, 0, 0);
        advance();
        n_checks++;
        if (d0_lookups !== 32'd6 || d0_hits !== 32'd5) begin
            n_errors++;
            $display("FAIL stats_count got %0d/%0d want 6/5", d0_lookups, d0_hits);
        end
        drive(1, 1, 0, {1'b1, 8'h01, 10'd1}, 0, 0, 0);
        stat_clr = 1'b1;
        advance();
        stat_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (d0_lookups !== 32'd0 || d0_hits !== 32'd0) begin
            n_errors++;
            $display("FAIL stats_clr got %0d/%0d want 0/0", d0_lookups, d0_hits);
        end
    endtask
`endif

    initial begin
        reset_model();
        test_reset();
        test_hit();
        test_miss();
        test_null_ptr();
        test_back_to_back();
        test_flush();
`ifdef TRIE_STAGE_STATS_EN
        test_stats();
`endif
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
